data_memory_arbiter: RTL and testbench

Shares the single-port data memory (10-bit address = 2-bit bank + 8-bit offset, 8-bit data) between two requesters:
- requester 0: control-unit load/store path.
- requester 1: secondary master (I/O / DMA-style port).

The block owns the memory's address-latch, read and write strobes and sequences each access through a fixed multi-cycle FSM. Requesters see a simple req/ack handshake.

---
 rtl/data_memory_arbiter_pkg.sv | 17 +
 rtl/data_memory_arbiter_arb_pick.sv | 45 ++++
 rtl/data_memory_arbiter.sv | 172 +++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared state encoding, arbitration modes and bus width defaults
package data_memory_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/data_memory_arbiter_arb_pick.sv
// rtl/data_memory_arbiter_arb_pick.sv - two-way request picker with last-served pointer
module data_memory_arbiter_arb_pick
    import data_memory_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic mode,
    input  logic served_valid,
    input  logic served_idx,
    output logic grant_idx,
    output logic grant_valid
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (served_valid) begin
            last_d = served_idx;
        end
    end

    // Reset as if requester 1 was served last so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = 1'b0;
        if (req0 && req1) begin
            grant_idx = mode ? 1'b0 : ~last_q;
        end else if (req1) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - sequences two requesters onto the single-port data memory
// Optional grant/conflict counters: DATA_MEMORY_ARBITER_STATS_EN
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE = PRIO_RR,
    parameter int ACCESS_WAIT   = 1,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_addr_wr_enable,
    output logic              mem_read_enable,
    output logic              mem_wr_enable,
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [7:0]        conflict_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] WAIT_LOAD = 3'(ACCESS_WAIT - 1);

    arb_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        wait_q, wait_d;
    logic              grant_idx;
    logic              grant_valid;

    data_memory_arbiter_arb_pick u_arb_pick (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .mode         (PRIORITY_MODE == PRIO_FIXED),
        .served_valid (state_q == DONE),
        .served_idx   (sel_q),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                // The request is committed here; later req changes cannot abort it.
                if (grant_valid) begin
                    sel_d   = grant_idx;
                    we_d    = grant_idx ? we1 : we0;
                    addr_d  = grant_idx ? addr1 : addr0;
                    wdata_d = grant_idx ? wdata1 : wdata0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                wait_d  = WAIT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (wait_q == 3'd0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        mem_addr_wr_enable = (state_q == ADDR);
        mem_read_enable    = (state_q == ACCESS) && !we_q;
        mem_wr_enable      = (state_q == ACCESS) && we_q;
        ack0               = (state_q == DONE) && !sel_q;
        ack1               = (state_q == DONE) && sel_q;
        busy               = (state_q != IDLE);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

`ifdef DATA_MEMORY_ARBITER_STATS_EN
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;
    logic [7:0]  ccnt_q, ccnt_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        ccnt_d  = ccnt_q;
        if (ack0 && (gcnt0_q != 16'hFFFF)) begin
            gcnt0_d = gcnt0_q + 16'd1;
        end
        if (ack1 && (gcnt1_q != 16'hFFFF)) begin
            gcnt1_d = gcnt1_q + 16'd1;
        end
        if ((state_q == IDLE) && req0 && req1 && (ccnt_q != 8'hFF)) begin
            ccnt_d = ccnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt0_q <= 16'd0;
            gcnt1_q <= 16'd0;
            ccnt_q  <= 8'd0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign grant_cnt0   = gcnt0_q;
    assign grant_cnt1   = gcnt1_q;
    assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - scoreboard bench over round-robin, fixed-priority and long-wait instances
module tb_data_memory_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;

    logic          ack0_o [ND];
    logic          ack1_o [ND];
    logic          busy_o [ND];
    logic          aw_o   [ND];
    logic          re_o   [ND];
    logic          wr_o   [ND];
    logic [AW-1:0] maddr_o  [ND];
    logic [DW-1:0] mwdata_o [ND];
    logic [DW-1:0] rdata_o  [ND];
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    logic [15:0]   gc0_o [ND];
    logic [15:0]   gc1_o [ND];
    logic [7:0]    cc_o  [ND];
`endif

    always #5 clk = ~clk;

    // Instance 0: round-robin, instance 1: fixed priority, instance 2: round-robin with 3 wait cycles.
    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_memory_arbiter #(
            .PRIORITY_MODE ((g == 1) ? 1 : 0),
            .ACCESS_WAIT   ((g == 2) ? 3 : 1),
            .ADDR_W        (AW),
            .DATA_W        (DW)
        ) u_dut (
            .clk                (clk),
            .reset              (reset),
            .req0               (req0),
            .we0                (we0),
            .addr0              (addr0),
            .wdata0             (wdata0),
            .ack0               (ack0_o[g]),
            .req1               (req1),
            .we1                (we1),
            .addr1              (addr1),
            .wdata1             (wdata1),
            .ack1               (ack1_o[g]),
            .rdata              (rdata_o[g]),
            .busy               (busy_o[g]),
            .mem_addr           (maddr_o[g]),
            .mem_wdata          (mwdata_o[g]),
            .mem_addr_wr_enable (aw_o[g]),
            .mem_read_enable    (re_o[g]),
            .mem_wr_enable      (wr_o[g]),
`ifdef DATA_MEMORY_ARBITER_STATS_EN
            .grant_cnt0         (gc0_o[g]),
            .grant_cnt1         (gc1_o[g]),
            .conflict_cnt       (cc_o[g]),
`endif
            .mem_rdata          (mem_rdata)
        );
    end

    typedef struct packed {
        logic [1:0]    dut;
        logic          who;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic          mon_en    [ND];
    logic [AW-1:0] seen_addr [ND];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_acc(input int d, input logic who, input logic rd,
                              input logic [AW-1:0] a, input logic [DW-1:0] dt);
        exp_t e;
        e.dut  = 2'(d);
        e.who  = who;
        e.rd   = rd;
        e.addr = a;
        e.data = dt;
        sbq.push_back(e);
    endtask

    task automatic expect_all(input logic who, input logic rd,
                              input logic [AW-1:0] a, input logic [DW-1:0] dt);
        for (int d = 0; d < ND; d++) expect_acc(d, who, rd, a, dt);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = !(busy_o[0] || busy_o[1] || busy_o[2]);
        end
        check_eq("wait_idle", 32'(done), 32'(1));
    endtask

    task automatic do_reset();
        wait_idle();
        check_eq("sb_empty", 32'(sbq.size()), 32'(0));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        int   idx;
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d_strobe_excl", d),
                     32'($countones({aw_o[d], re_o[d], wr_o[d]}) > 1), 32'(0));
            check_eq($sformatf("d%0d_ack_excl", d), 32'(ack0_o[d] & ack1_o[d]), 32'(0));
            if (aw_o[d]) seen_addr[d] = maddr_o[d];
            if (mon_en[d] && (ack0_o[d] || ack1_o[d])) begin
                idx = -1;
                foreach (sbq[i]) if (idx < 0 && sbq[i].dut == 2'(d)) idx = i;
                if (idx < 0) begin
                    check_eq($sformatf("d%0d_unexpected_ack", d), 32'(1), 32'(0));
                end else begin
                    e = sbq[idx];
                    sbq.delete(idx);
                    check_eq($sformatf("d%0d_ack_who", d), 32'(ack1_o[d]), 32'(e.who));
                    check_eq($sformatf("d%0d_ack_addr", d), 32'(seen_addr[d]), 32'(e.addr));
                    if (e.rd) check_eq($sformatf("d%0d_ack_rdata", d), 32'(rdata_o[d]), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acks;
        for (int d = 0; d < ND; d++) begin
            mon_en[d]    = 1'b1;
            seen_addr[d] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d_rst_ctl", d),
                     32'({ack0_o[d], ack1_o[d], busy_o[d], aw_o[d], re_o[d], wr_o[d]}), 32'(0));
            check_eq($sformatf("d%0d_rst_maddr", d), 32'(maddr_o[d]), 32'(0));
            check_eq($sformatf("d%0d_rst_mwdata", d), 32'(mwdata_o[d]), 32'(0));
            check_eq($sformatf("d%0d_rst_rdata", d), 32'(rdata_o[d]), 32'(0));
        end
        @(posedge clk); #1 reset = 1'b0;

        // Single read from requester 0.
        mem_rdata = 8'hA5; we0 = 1'b0; addr0 = 10'h2F0; req0 = 1'b1;
        expect_all(1'b0, 1'b1, 10'h2F0, 8'hA5);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_eq($sformatf("t1_c%0d_aw", c), 32'(aw_o[0]), 32'(c == 1));
            check_eq($sformatf("t1_c%0d_re", c), 32'(re_o[0]), 32'(c == 2));
            check_eq($sformatf("t1_c%0d_ack0", c), 32'(ack0_o[0]), 32'(c == 3));
            check_eq($sformatf("t1_c%0d_busy", c), 32'(busy_o[0]), 32'(c >= 1 && c <= 3));
            check_eq($sformatf("t1_c%0d_w3_re", c), 32'(re_o[2]), 32'(c >= 2 && c <= 4));
            check_eq($sformatf("t1_c%0d_w3_ack0", c), 32'(ack0_o[2]), 32'(c == 5));
            if (c == 3) req0 = 1'b0;
        end
`ifdef DATA_MEMORY_ARBITER_STATS_EN
        check_eq("t1_w3_grant_cnt0", 32'(gc0_o[2]), 32'(1));
        check_eq("t1_grant_cnt0", 32'(gc0_o[0]), 32'(1));
`endif

        // Single write from requester 1 to the top address.
        @(posedge clk); #1;
        we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 8'h3C; req1 = 1'b1;
        expect_all(1'b1, 1'b0, 10'h3FF, 8'h00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("t2_c%0d_wr", c), 32'(wr_o[0]), 32'(c == 2));
            check_eq($sformatf("t2_c%0d_re", c), 32'(re_o[0]), 32'(0));
            check_eq($sformatf("t2_c%0d_ack1", c), 32'(ack1_o[0]), 32'(c == 3));
            if (c == 2) begin
                check_eq("t2_maddr", 32'(maddr_o[0]), 32'(10'h3FF));
                check_eq("t2_mwdata", 32'(mwdata_o[0]), 32'(8'h3C));
            end
            if (c == 3) begin
                check_eq("t2_rdata_held", 32'(rdata_o[0]), 32'(8'hA5));
                req1 = 1'b0;
            end
        end

        // Both requesters held: round-robin alternates, fixed priority serves only requester 0.
        do_reset();
        mon_en[2] = 1'b0;
        mem_rdata = 8'h5A;
        we0 = 1'b0; addr0 = 10'h000; we1 = 1'b0; addr1 = 10'h3FF;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_acc(0, 1'(k % 2), 1'b1, (k % 2) ? 10'h3FF : 10'h000, 8'h5A);
            expect_acc(1, 1'b0, 1'b1, 10'h000, 8'h5A);
        end
        acks = 0;
        for (int c = 0; c < 40 && acks < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t3_c%0d_fp_ack1", c), 32'(ack1_o[1]), 32'(0));
            if (ack0_o[0] || ack1_o[0]) acks++;
            if (acks == 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        check_eq("t3_ack_count", 32'(acks), 32'(4));
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();
`ifdef DATA_MEMORY_ARBITER_STATS_EN
        check_eq("t3_rr_gc0", 32'(gc0_o[0]), 32'(2));
        check_eq("t3_rr_gc1", 32'(gc1_o[0]), 32'(2));
        check_eq("t3_rr_conflict", 32'(cc_o[0]), 32'(4));
        check_eq("t3_fp_gc0", 32'(gc0_o[1]), 32'(4));
        check_eq("t3_fp_conflict", 32'(cc_o[1]), 32'(4));
`endif

        // Requester 0 withdraws during ACCESS; the access still completes.
        do_reset();
        mon_en[2] = 1'b1;
        mem_rdata = 8'hC3; we0 = 1'b0; addr0 = 10'h155; req0 = 1'b1;
        expect_all(1'b0, 1'b1, 10'h155, 8'hC3);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq($sformatf("t4_c%0d_ack0", c), 32'(ack0_o[0]), 32'(c == 3));
            check_eq($sformatf("t4_c%0d_busy", c), 32'(busy_o[0]), 32'(c >= 1 && c <= 3));
            if (c == 2) req0 = 1'b0;
        end
        wait_idle();

        // Reset during a write ACCESS aborts it without an ack and clears rdata.
        @(posedge clk); #1;
        we0 = 1'b1; addr0 = 10'h0AA; wdata0 = 8'h77; req0 = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge clk);
        check_eq("t5_wr_before_rst", 32'(wr_o[0]), 32'(1));
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("t5_d%0d_strobes", d), 32'({aw_o[d], re_o[d], wr_o[d]}), 32'(0));
            check_eq($sformatf("t5_d%0d_busy", d), 32'(busy_o[d]), 32'(0));
            check_eq($sformatf("t5_d%0d_rdata", d), 32'(rdata_o[d]), 32'(0));
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("t5_post_c%0d_busy", c), 32'(busy_o[0]), 32'(0));
        end

        @(posedge clk); #1;
        mem_rdata = 8'h96; we0 = 1'b0; addr0 = 10'h000; req0 = 1'b1;
        expect_all(1'b0, 1'b1, 10'h000, 8'h96);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t5_rd_c%0d_ack0", c), 32'(ack0_o[0]), 32'(c == 3));
            if (c == 3) req0 = 1'b0;
        end
        wait_idle();
        check_eq("final_sb_empty", 32'(sbq.size()), 32'(0));
`ifdef DATA_MEMORY_ARBITER_STATS_EN
        check_eq("t5_gc0_after_rst", 32'(gc0_o[0]), 32'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
